// File: rtl/ita_package.sv
// rtl/ita_package.sv - shared lane count, constant types and activation modes
package ita_package;

    localparam int unsigned N            = 4;
    localparam int unsigned GELU_CONST_W = 16;
    localparam int unsigned GELU_OUT_W   = 32;
    localparam int unsigned EMS          = 8;

    typedef logic signed [GELU_CONST_W-1:0] gelu_const_t;
    typedef logic signed [GELU_OUT_W-1:0]   gelu_out_t;
    typedef logic        [EMS-1:0]          requant_const_t;

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        RELU     = 2'd1,
        GELU     = 2'd2,
        CLIP     = 2'd3
    } activation_e;

endpackage

// File: rtl/ita_clip.sv
// rtl/ita_clip.sv - one-lane signed clamp, upper bound wins when bounds cross
module ita_clip #(
    parameter int WI = 8
) (
    input  logic signed [WI-1:0] data_i,
    input  logic signed [WI-1:0] lo_i,
    input  logic signed [WI-1:0] hi_i,
    output logic signed [WI-1:0] data_o
);

    logic signed [WI-1:0] lo_clamped;

    assign lo_clamped = (data_i < lo_i) ? lo_i : data_i;
    assign data_o     = (lo_clamped > hi_i) ? hi_i : lo_clamped;

endmodule

// File: rtl/ita_gelu.sv
// rtl/ita_gelu.sv - integer polynomial GELU for one lane, combinational
module ita_gelu
    import ita_package::*;
#(
    parameter int WI = 8
) (
    input  logic signed [WI-1:0] data_i,
    input  gelu_const_t          one_i,
    input  gelu_const_t          b_i,
    input  gelu_const_t          c_i,
    output gelu_out_t            gelu_o
);

    gelu_out_t x, q_abs, q_clip, d, erf_l, q_erf;

    // erf(x) ~ sign(x) * ((min(|x|, -b) + b)^2 + c); gelu = x * (erf + one)
    always_comb begin
        x      = gelu_out_t'(data_i);
        q_abs  = x[GELU_OUT_W-1] ? -x : x;
        q_clip = (q_abs > -gelu_out_t'(b_i)) ? -gelu_out_t'(b_i) : q_abs;
        d      = q_clip + gelu_out_t'(b_i);
        erf_l  = d * d + gelu_out_t'(c_i);
        q_erf  = x[GELU_OUT_W-1] ? -erf_l : erf_l;
        gelu_o = x * (q_erf + gelu_out_t'(one_i));
    end

endmodule

// File: rtl/ita_relu.sv
// rtl/ita_relu.sv - one-lane rectifier
module ita_relu #(
    parameter int WI = 8
) (
    input  logic signed [WI-1:0] data_i,
    output logic signed [WI-1:0] data_o
);

    assign data_o = data_i[WI-1] ? '0 : data_i;

endmodule

// File: rtl/ita_requantizer.sv
// rtl/ita_requantizer.sv - N-wide multiply, shift, offset and saturate in two registered steps
module ita_requantizer
    import ita_package::*;
#(
    parameter int N  = 4,
    parameter int WI = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mode_i,
    input  requant_const_t       eps_mult_i,
    input  requant_const_t       right_shift_i,
    input  requant_const_t       add_i,
    input  logic                 calc_en_i,
    input  logic                 calc_en_q_i,
    input  gelu_out_t [N-1:0]    result_i,
    output logic [N-1:0][WI-1:0] requant_o
);

    localparam int PW = GELU_OUT_W + EMS + 1;
    typedef logic signed [PW-1:0] prod_t;
    localparam prod_t SAT_MAX = prod_t'((2 ** (WI - 1)) - 1);
    localparam prod_t SAT_MIN = -SAT_MAX - prod_t'(1);

    prod_t                prod_q [N];
    prod_t                rnd, shifted;
    logic [N-1:0][WI-1:0] requant_d;

    // mode 1 rounds to nearest before the arithmetic shift
    always_comb begin
        requant_d = '0;
        shifted   = '0;
        rnd       = (mode_i && right_shift_i != '0) ? (prod_t'(1) <<< (right_shift_i - 8'd1)) : '0;
        for (int l = 0; l < N; l++) begin
            shifted = ((prod_q[l] + rnd) >>> right_shift_i) + prod_t'($signed(add_i));
            if (shifted > SAT_MAX)      requant_d[l] = SAT_MAX[WI-1:0];
            else if (shifted < SAT_MIN) requant_d[l] = SAT_MIN[WI-1:0];
            else                        requant_d[l] = shifted[WI-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < N; l++) prod_q[l] <= '0;
            requant_o <= '0;
        end else begin
            if (calc_en_i) begin
                for (int l = 0; l < N; l++)
                    prod_q[l] <= prod_t'($signed(result_i[l])) * prod_t'($signed({1'b0, eps_mult_i}));
            end
            if (calc_en_q_i) requant_o <= requant_d;
        end
    end

endmodule

// File: rtl/ita_activation_stream.sv
// rtl/ita_activation_stream.sv - N-lane activation with per-beat mode on a 2-stage valid/ready pipeline
module ita_activation_stream
    import ita_package::*;
#(
    parameter int N       = ita_package::N,
    parameter int WI      = 8,
    parameter bit CLIP_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  gelu_const_t          one_i,
    input  gelu_const_t          b_i,
    input  gelu_const_t          c_i,
    input  logic                 requant_mode_i,
    input  requant_const_t       requant_mult_i,
    input  requant_const_t       requant_shift_i,
    input  requant_const_t       requant_add_i,
    input  logic signed [WI-1:0] clip_lo_i,
    input  logic signed [WI-1:0] clip_hi_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  activation_e          activation_i,
    input  logic                 last_i,
    input  logic [N*WI-1:0]      data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic [N*WI-1:0]      data_o,
    output logic                 busy_o
);

    logic                 en1, en2;
    logic                 v1_q, v2_q;
    logic [N*WI-1:0]      data_q1, data_q2;
    activation_e          act_q1, act_q2;
    logic                 last_q1, last_q2;
    logic [1:0]           occ_q;
    logic                 in_hs, out_hs;
    gelu_out_t [N-1:0]    gelu_d;
    logic [N-1:0][WI-1:0] gelu_q, relu_d, clip_d;

    // stage 1 may refill while stage 2 is stalled
    assign en2     = !v2_q || ready_i;
    assign en1     = !v1_q || en2;
    assign ready_o = en1;
    assign in_hs   = valid_i && en1;
    assign out_hs  = v2_q && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            data_q1 <= '0;
            data_q2 <= '0;
            act_q1  <= IDENTITY;
            act_q2  <= IDENTITY;
            last_q1 <= 1'b0;
            last_q2 <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            if (en1) begin
                v1_q    <= valid_i;
                data_q1 <= data_i;
                act_q1  <= activation_i;
                last_q1 <= last_i;
            end
            if (en2) begin
                v2_q    <= v1_q;
                data_q2 <= data_q1;
                act_q2  <= act_q1;
                last_q2 <= last_q1;
            end
            if (in_hs != out_hs) occ_q <= in_hs ? occ_q + 2'd1 : occ_q - 2'd1;
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_lane
        logic signed [WI-1:0] lane_q2;
        assign lane_q2 = data_q2[l*WI +: WI];

        ita_gelu #(.WI(WI)) i_gelu (
            .data_i (data_i[l*WI +: WI]),
            .one_i  (one_i),
            .b_i    (b_i),
            .c_i    (c_i),
            .gelu_o (gelu_d[l])
        );

        ita_relu #(.WI(WI)) i_relu (
            .data_i (lane_q2),
            .data_o (relu_d[l])
        );

        if (CLIP_EN) begin : g_clip
            ita_clip #(.WI(WI)) i_clip (
                .data_i (lane_q2),
                .lo_i   (clip_lo_i),
                .hi_i   (clip_hi_i),
                .data_o (clip_d[l])
            );
        end else begin : g_no_clip
            assign clip_d[l] = lane_q2;
        end
    end

    ita_requantizer #(.N(N), .WI(WI)) i_requantizer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .mode_i        (requant_mode_i),
        .eps_mult_i    (requant_mult_i),
        .right_shift_i (requant_shift_i),
        .add_i         (requant_add_i),
        .calc_en_i     (en1),
        .calc_en_q_i   (en2),
        .result_i      (gelu_d),
        .requant_o     (gelu_q)
    );

    always_comb begin
        data_o = data_q2;
        for (int l = 0; l < N; l++) begin
            case (act_q2)
                RELU:    data_o[l*WI +: WI] = relu_d[l];
                GELU:    data_o[l*WI +: WI] = gelu_q[l];
                CLIP:    data_o[l*WI +: WI] = clip_d[l];
                default: data_o[l*WI +: WI] = data_q2[l*WI +: WI];
            endcase
        end
    end

    assign valid_o = v2_q;
    assign last_o  = last_q2;
    assign busy_o  = (occ_q != 2'd0);

endmodule
